// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit that sits beside the execute stage.
// It handles one M-extension operation at a time. UNROLL bits are
// processed per cycle, and the pipeline is held through a stall request.
//
// state | meaning
// IDLE  | waiting for start_in; operands, signs and special cases decoded here
// CALC  | shift-add multiply or restoring divide, N = XLEN/UNROLL cycles
// FIX   | sign correction and result selection, registered into result_out
// DONE  | done_out / rd_out valid for this single cycle
module ex_muldiv #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            start_in,
    input  logic [2:0]      op_in,
    input  logic [XLEN-1:0] rs1_val_in,
    input  logic [XLEN-1:0] rs2_val_in,
    input  logic [4:0]      rd_addr_in,
    input  logic            flush_in,
    output logic            busy_out,
    output logic            stallreq_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out,
    output logic            rd_out,
    output logic [4:0]      rd_addr_out
);

    localparam int N  = XLEN / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(N - 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;
    logic [4:0]          rd_addr_q;
    logic                neg_quo_q, neg_rem_q;
    logic [XLEN-1:0]     opnd_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     result_q;

    logic                accept;
    logic                signed_a, signed_b, sign_a, sign_b;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic                div_zero, div_ovf, special;
    logic [XLEN-1:0]     special_val;
    logic [2*XLEN-1:0]   acc_step;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix, rem_fix, fix_val;

    assign accept = (state_q == S_IDLE) && start_in && !flush_in;

    // Operand signedness and magnitudes; the most-negative value wraps onto itself.
    assign signed_a = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
                      (op_in == OP_DIV)  || (op_in == OP_REM);
    assign signed_b = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    assign sign_a   = signed_a && rs1_val_in[XLEN-1];
    assign sign_b   = signed_b && rs2_val_in[XLEN-1];
    assign mag_a    = sign_a ? -rs1_val_in : rs1_val_in;
    assign mag_b    = sign_b ? -rs2_val_in : rs2_val_in;

    // Divide-by-zero and signed overflow resolve at accept and skip CALC entirely.
    assign div_zero = op_in[2] && (rs2_val_in == '0);
    assign div_ovf  = op_in[2] && !op_in[0] &&
                      (rs1_val_in == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val_in == '1);
    assign special  = div_zero || div_ovf;
    assign special_val = div_zero ? (op_in[1] ? rs1_val_in : '1)
                                  : (op_in[1] ? '0 : rs1_val_in);

    // One iteration cycle. For multiply, acc holds {partial product, remaining multiplier}.
    // For divide, acc holds {partial remainder, dividend/quotient}.
    always_comb begin : calc_step
        logic [XLEN:0]     part;
        logic [2*XLEN-1:0] p;
        p    = acc_q;
        part = '0;
        for (int i = 0; i < UNROLL; i++) begin
            if (op_q[2]) begin
                part = {p[2*XLEN-1:XLEN], p[XLEN-1]};
                if (part >= {1'b0, opnd_q}) begin
                    part = part - {1'b0, opnd_q};
                    p    = {part[XLEN-1:0], p[XLEN-2:0], 1'b1};
                end else begin
                    p    = {part[XLEN-1:0], p[XLEN-2:0], 1'b0};
                end
            end else begin
                if (p[0]) begin
                    part = {1'b0, p[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
                end else begin
                    part = {1'b0, p[2*XLEN-1:XLEN]};
                end
                p = {part, p[XLEN-1:1]};
            end
        end
        acc_step = p;
    end

    // Sign correction and selection of the final result.
    always_comb begin
        prod_fix = neg_quo_q ? -acc_q : acc_q;
        quo_fix  = neg_quo_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        fix_val  = rem_fix;
        case (op_q)
            OP_MUL:                      fix_val = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             fix_val = quo_fix;
            default:                     fix_val = rem_fix;
        endcase
    end

    // Next-state logic; flush returns to IDLE from every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_in) state_d = S_IDLE;
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q     <= '0;
            op_q      <= '0;
            rd_addr_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else if (accept) begin
            op_q      <= op_in;
            rd_addr_q <= rd_addr_in;
            neg_quo_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            cnt_q     <= CNT_LOAD;
            if (op_in[2]) begin
                opnd_q <= mag_b;
                acc_q  <= {{XLEN{1'b0}}, mag_a};
            end else begin
                opnd_q <= mag_a;
                acc_q  <= {{XLEN{1'b0}}, mag_b};
            end
            if (special) result_q <= special_val;
        end else if (state_q == S_CALC) begin
            acc_q <= acc_step;
            if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end else if ((state_q == S_FIX) && !flush_in) begin
            result_q <= fix_val;
        end
    end

    assign busy_out     = (state_q != S_IDLE);
    assign stallreq_out = accept || (state_q == S_CALC) || (state_q == S_FIX);
    assign done_out     = (state_q == S_DONE);
    assign rd_out       = (state_q == S_DONE) && (rd_addr_q != 5'd0);
    assign rd_addr_out  = rd_addr_q;
    assign result_out   = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv. One instance uses UNROLL=1 and one uses
// UNROLL=4; they share every input except start.
module tb_ex_muldiv;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start4 = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd_addr = '0;
    logic        flush = 1'b0;

    logic        busy, stallreq, done, rd;
    logic [31:0] result;
    logic [4:0]  rd_addr_o;
    logic        busy4, stallreq4, done4, rd4;
    logic [31:0] result4;
    logic [4:0]  rd_addr_o4;

    int total = 0;
    int passed = 0;
    int failed = 0;

    ex_muldiv #(.XLEN(32), .UNROLL(1)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start), .op_in(op),
        .rs1_val_in(rs1), .rs2_val_in(rs2), .rd_addr_in(rd_addr), .flush_in(flush),
        .busy_out(busy), .stallreq_out(stallreq), .done_out(done),
        .result_out(result), .rd_out(rd), .rd_addr_out(rd_addr_o)
    );

    ex_muldiv #(.XLEN(32), .UNROLL(4)) dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .start_in(start4), .op_in(op),
        .rs1_val_in(rs1), .rs2_val_in(rs2), .rd_addr_in(rd_addr), .flush_in(flush),
        .busy_out(busy4), .stallreq_out(stallreq4), .done_out(done4),
        .result_out(result4), .rd_out(rd4), .rd_addr_out(rd_addr_o4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation from the current IDLE cycle (cycle 0). It checks the
    // done cycle, the result, rd info, the stall window and the one-cycle done
    // pulse. A nonzero pulse_cyc re-pulses start with junk operands mid-flight.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r,
                          input logic [31:0] exp_res, input int exp_cyc, input int pulse_cyc);
        int cyc;
        bit stall_ok;
        op = o; rs1 = a; rs2 = b; rd_addr = r; start = 1'b1;
        #1;
        stall_ok = (stallreq === 1'b1);
        step();
        start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 120) begin
            if (stallreq !== 1'b1) stall_ok = 1'b0;
            if (cyc == pulse_cyc) begin
                start = 1'b1; op = OP_MUL; rs1 = 32'h1234; rs2 = 32'h5678; rd_addr = 5'd31;
            end
            step();
            start = 1'b0; op = o; rs1 = a; rs2 = b; rd_addr = r;
            cyc++;
        end
        if (stallreq !== 1'b0) stall_ok = 1'b0;
        chk({tag, " done cycle"}, 32'(cyc), 32'(exp_cyc));
        chk({tag, " result"}, result, exp_res);
        chk({tag, " rd_out"}, {31'b0, rd}, {31'b0, (r != 5'd0)});
        chk({tag, " rd_addr"}, {27'b0, rd_addr_o}, {27'b0, r});
        chk({tag, " stall window"}, {31'b0, stall_ok}, 32'd1);
        step();
        chk({tag, " done pulse width"}, {30'b0, done, busy}, 32'd0);
    endtask

    initial begin
        int  cyc;
        bit  flag;

        rst_n = 1'b0;
        step();
        step();
        chk("reset outputs", {22'b0, busy, stallreq, done, rd, rd_addr_o, result[0]}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset outputs u4", {23'b0, busy4, stallreq4, done4, rd4, rd_addr_o4}, 32'd0);
        rst_n = 1'b1;
        step();

        run_op("MUL",    OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34, 0);
        run_op("MULH",   OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 34, 0);
        run_op("MULHU",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 34, 0);
        run_op("MULHSU", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 34, 0);
        run_op("MULH m1", OP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 34, 0);
        run_op("DIV",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 34, 0);
        run_op("REM",    OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 34, 0);
        run_op("DIV negB", OP_DIV,  32'd20,        32'hFFFF_FFFA, 5'd11, 32'hFFFF_FFFD, 34, 0);
        run_op("REM negB", OP_REM,  32'd20,        32'hFFFF_FFFA, 5'd11, 32'd2,         34, 0);
        run_op("DIVU",   OP_DIVU,   32'd100,       32'd7,         5'd12, 32'd14,        34, 0);
        run_op("REMU",   OP_REMU,   32'd100,       32'd7,         5'd13, 32'd2,         34, 0);

        run_op("DIV by0",  OP_DIV,  32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1, 0);
        run_op("REM by0",  OP_REM,  32'd5,         32'd0,         5'd15, 32'd5,         1, 0);
        run_op("DIVU by0", OP_DIVU, 32'd9,         32'd0,         5'd16, 32'hFFFF_FFFF, 1, 0);
        run_op("DIV ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 1, 0);
        run_op("REM ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0,         1, 0);

        run_op("DIVU start while busy", OP_DIVU, 32'd100, 32'd7, 5'd19, 32'd14, 34, 5);
        run_op("MUL rd0", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd0, 32'hFFFF_FFEB, 34, 0);

        // Flush in the same cycle as start: nothing is accepted.
        op = OP_DIVU; rs1 = 32'd50; rs2 = 32'd3; rd_addr = 5'd4; start = 1'b1; flush = 1'b1;
        #1;
        chk("flush+start stallreq", {31'b0, stallreq}, 32'd0);
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush+start busy", {31'b0, busy}, 32'd0);

        // Flush in cycle 10 of a DIV; a MUL starting in cycle 11 finishes 34 cycles later.
        op = OP_DIV; rs1 = 32'd100; rs2 = 32'd7; rd_addr = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        flag = 1'b0;
        while (cyc < 10) begin
            if (done === 1'b1) flag = 1'b1;
            step();
            cyc++;
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush busy low", {31'b0, busy}, 32'd0);
        chk("flush no done", {30'b0, done, flag}, 32'd0);
        chk("flush keeps result", result, 32'hFFFF_FFEB);
        run_op("MUL after flush", OP_MUL, 32'd3, 32'd5, 5'd21, 32'd15, 34, 0);

        // Flush during DONE: done_out still pulses.
        op = OP_DIV; rs1 = 32'd5; rs2 = 32'd0; rd_addr = 5'd22; start = 1'b1;
        step();
        start = 1'b0; flush = 1'b1;
        chk("flush in DONE done", {31'b0, done}, 32'd1);
        step();
        flush = 1'b0;
        chk("flush in DONE idle", {30'b0, done, busy}, 32'd0);

        // Asynchronous reset in cycle 5 of a MUL.
        op = OP_MUL; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; rd_addr = 5'd9; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("async reset flags", {23'b0, busy, stallreq, done, rd, rd_addr_o}, 32'd0);
        chk("async reset result", result, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (40) begin
            step();
            if (done === 1'b1 || busy === 1'b1) flag = 1'b1;
        end
        chk("no done after reset", {31'b0, flag}, 32'd0);

        // UNROLL=4 instance: N = 8, done in cycle 10.
        op = OP_MUL; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; rd_addr = 5'd5; start4 = 1'b1;
        step();
        start4 = 1'b0;
        cyc = 1;
        while (done4 !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
        chk("U4 MUL done cycle", 32'(cyc), 32'd10);
        chk("U4 MUL result", result4, 32'hFFFF_FFEB);
        step();

        op = OP_DIV; rs1 = 32'hFFFF_FFF9; rs2 = 32'd2; rd_addr = 5'd6; start4 = 1'b1;
        step();
        start4 = 1'b0;
        cyc = 1;
        while (done4 !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
        end
        chk("U4 DIV done cycle", 32'(cyc), 32'd10);
        chk("U4 DIV result", result4, 32'hFFFF_FFFD);
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
